// File: rtl/vanilla_sb_clear_gen_if.sv
//------------------------------------------------------------------------------
// Module  : vanilla_sb_clear_gen_if
// Brief   : Response/long-op/writeback bundle for the scoreboard clear generator.
//           Check ports exist only with VANILLA_SB_CLEAR_CHECK_EN defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vanilla_sb_clear_gen_if #(
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5
) ();
  logic                        remote_v_i;
  logic                        remote_float_i;
  logic [reg_addr_width_p-1:0] remote_id_i;
  logic [data_width_p-1:0]     remote_data_i;
  logic                        remote_ready_o;
  logic                        idiv_v_i;
  logic [reg_addr_width_p-1:0] idiv_id_i;
  logic [data_width_p-1:0]     idiv_data_i;
  logic                        idiv_yumi_o;
  logic                        fdiv_v_i;
  logic [reg_addr_width_p-1:0] fdiv_id_i;
  logic [data_width_p-1:0]     fdiv_data_i;
  logic                        fdiv_yumi_o;
  logic                        int_wb_stall_i;
  logic                        float_wb_stall_i;
  logic                        int_sb_clear_o;
  logic [reg_addr_width_p-1:0] int_sb_clear_id_o;
  logic [data_width_p-1:0]     int_wb_data_o;
  logic                        float_sb_clear_o;
  logic [reg_addr_width_p-1:0] float_sb_clear_id_o;
  logic [data_width_p-1:0]     float_wb_data_o;
  logic                        err_o;
`ifdef VANILLA_SB_CLEAR_CHECK_EN
  logic                        int_sb_set_i;
  logic [reg_addr_width_p-1:0] int_sb_set_id_i;
  logic                        float_sb_set_i;
  logic [reg_addr_width_p-1:0] float_sb_set_id_i;
`endif

  modport slave (
    input  remote_v_i, remote_float_i, remote_id_i, remote_data_i,
    output remote_ready_o,
    input  idiv_v_i, idiv_id_i, idiv_data_i,
    output idiv_yumi_o,
    input  fdiv_v_i, fdiv_id_i, fdiv_data_i,
    output fdiv_yumi_o,
    input  int_wb_stall_i, float_wb_stall_i,
    output int_sb_clear_o, int_sb_clear_id_o, int_wb_data_o,
    output float_sb_clear_o, float_sb_clear_id_o, float_wb_data_o,
`ifdef VANILLA_SB_CLEAR_CHECK_EN
    input  int_sb_set_i, int_sb_set_id_i, float_sb_set_i, float_sb_set_id_i,
`endif
    output err_o
  );

  modport master (
    output remote_v_i, remote_float_i, remote_id_i, remote_data_i,
    input  remote_ready_o,
    output idiv_v_i, idiv_id_i, idiv_data_i,
    input  idiv_yumi_o,
    output fdiv_v_i, fdiv_id_i, fdiv_data_i,
    input  fdiv_yumi_o,
    output int_wb_stall_i, float_wb_stall_i,
    input  int_sb_clear_o, int_sb_clear_id_o, int_wb_data_o,
    input  float_sb_clear_o, float_sb_clear_id_o, float_wb_data_o,
`ifdef VANILLA_SB_CLEAR_CHECK_EN
    output int_sb_set_i, int_sb_set_id_i, float_sb_set_i, float_sb_set_id_i,
`endif
    input  err_o
  );
endinterface

`default_nettype wire

// File: rtl/vanilla_sb_clear_gen.sv
//------------------------------------------------------------------------------
// Module  : vanilla_sb_clear_gen
// Brief   : Arbitrates remote/idiv/fdiv completions onto int/float writeback and
//           pulses scoreboard clears. Optional checker: VANILLA_SB_CLEAR_CHECK_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vanilla_sb_clear_gen #(
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5,
  parameter int fifo_els_p       = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  vanilla_sb_clear_gen_if.slave bus
);

  localparam int c_ptr_w = $clog2(fifo_els_p);
  localparam int c_cnt_w = $clog2(fifo_els_p + 1);

  logic                        r_fifo_float [fifo_els_p];
  logic [reg_addr_width_p-1:0] r_fifo_id    [fifo_els_p];
  logic [data_width_p-1:0]     r_fifo_data  [fifo_els_p];
  logic [c_ptr_w-1:0]          r_wr_ptr, r_rd_ptr;
  logic [c_cnt_w-1:0]          r_count;

  logic                        r_int_last_rem, r_float_last_rem;
  logic                        r_int_clear, r_float_clear;
  logic [reg_addr_width_p-1:0] r_int_id, r_float_id;
  logic [data_width_p-1:0]     r_int_data, r_float_data;

  logic w_push, w_pop, w_head_v, w_head_float;
  logic w_int_rem_req, w_float_rem_req;
  logic w_int_gnt_div, w_int_gnt_rem, w_float_gnt_div, w_float_gnt_rem;

  assign bus.remote_ready_o = (r_count < c_cnt_w'(fifo_els_p));
  assign w_push             = bus.remote_v_i & bus.remote_ready_o;
  assign w_head_v           = (r_count != '0);
  assign w_head_float       = r_fifo_float[r_rd_ptr];
  assign w_int_rem_req      = w_head_v & ~w_head_float;
  assign w_float_rem_req    = w_head_v &  w_head_float;

  // On a tie the source that did not win last time gets the port.
  assign w_int_gnt_div   = ~bus.int_wb_stall_i & bus.idiv_v_i & (~w_int_rem_req | r_int_last_rem);
  assign w_int_gnt_rem   = ~bus.int_wb_stall_i & w_int_rem_req & (~bus.idiv_v_i | ~r_int_last_rem);
  assign w_float_gnt_div = ~bus.float_wb_stall_i & bus.fdiv_v_i & (~w_float_rem_req | r_float_last_rem);
  assign w_float_gnt_rem = ~bus.float_wb_stall_i & w_float_rem_req & (~bus.fdiv_v_i | ~r_float_last_rem);
  assign w_pop           = w_int_gnt_rem | w_float_gnt_rem;

  assign bus.idiv_yumi_o = w_int_gnt_div;
  assign bus.fdiv_yumi_o = w_float_gnt_div;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_float[r_wr_ptr] <= bus.remote_float_i;
      r_fifo_id[r_wr_ptr]    <= bus.remote_id_i;
      r_fifo_data[r_wr_ptr]  <= bus.remote_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      r_int_last_rem   <= 1'b1;
      r_float_last_rem <= 1'b1;
      r_int_clear      <= 1'b0;
      r_float_clear    <= 1'b0;
      r_int_id         <= '0;
      r_float_id       <= '0;
      r_int_data       <= '0;
      r_float_data     <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      r_int_clear <= w_int_gnt_div | w_int_gnt_rem;
      if (w_int_gnt_div | w_int_gnt_rem) r_int_last_rem <= w_int_gnt_rem;
      if (w_int_gnt_div) begin
        r_int_id   <= bus.idiv_id_i;
        r_int_data <= bus.idiv_data_i;
      end else if (w_int_gnt_rem) begin
        r_int_id   <= r_fifo_id[r_rd_ptr];
        r_int_data <= r_fifo_data[r_rd_ptr];
      end

      r_float_clear <= w_float_gnt_div | w_float_gnt_rem;
      if (w_float_gnt_div | w_float_gnt_rem) r_float_last_rem <= w_float_gnt_rem;
      if (w_float_gnt_div) begin
        r_float_id   <= bus.fdiv_id_i;
        r_float_data <= bus.fdiv_data_i;
      end else if (w_float_gnt_rem) begin
        r_float_id   <= r_fifo_id[r_rd_ptr];
        r_float_data <= r_fifo_data[r_rd_ptr];
      end
    end
  end

  assign bus.int_sb_clear_o      = r_int_clear;
  assign bus.int_sb_clear_id_o   = r_int_id;
  assign bus.int_wb_data_o       = r_int_data;
  assign bus.float_sb_clear_o    = r_float_clear;
  assign bus.float_sb_clear_id_o = r_float_id;
  assign bus.float_wb_data_o     = r_float_data;

`ifdef VANILLA_SB_CLEAR_CHECK_EN
  localparam int c_regs = 2 ** reg_addr_width_p;

  logic [c_regs-1:0] r_int_pend, r_float_pend;
  logic [c_regs-1:0] w_int_set, w_int_clr, w_float_set, w_float_clr;
  logic              r_err, w_int_bad_clr, w_float_bad_clr, w_int_bad_set, w_float_bad_set;

  always_comb begin
    w_int_set   = '0;
    w_int_clr   = '0;
    w_float_set = '0;
    w_float_clr = '0;
    if (bus.int_sb_set_i)   w_int_set[bus.int_sb_set_id_i]     = 1'b1;
    if (r_int_clear)        w_int_clr[r_int_id]                = 1'b1;
    if (bus.float_sb_set_i) w_float_set[bus.float_sb_set_id_i] = 1'b1;
    if (r_float_clear)      w_float_clr[r_float_id]            = 1'b1;
  end

  // A set landing on an id that is being cleared this cycle is legitimate reuse.
  assign w_int_bad_clr   = r_int_clear & ~r_int_pend[r_int_id];
  assign w_float_bad_clr = r_float_clear & ~r_float_pend[r_float_id];
  assign w_int_bad_set   = bus.int_sb_set_i & r_int_pend[bus.int_sb_set_id_i] & ~w_int_clr[bus.int_sb_set_id_i];
  assign w_float_bad_set = bus.float_sb_set_i & r_float_pend[bus.float_sb_set_id_i] & ~w_float_clr[bus.float_sb_set_id_i];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_int_pend   <= '0;
      r_float_pend <= '0;
      r_err        <= 1'b0;
    end else begin
      r_int_pend   <= (r_int_pend & ~w_int_clr) | w_int_set;
      r_float_pend <= (r_float_pend & ~w_float_clr) | w_float_set;
      if (w_int_bad_clr | w_float_bad_clr | w_int_bad_set | w_float_bad_set) r_err <= 1'b1;
      if (w_int_bad_clr)   $error("int clear of non-pending id %0d", r_int_id);
      if (w_float_bad_clr) $error("float clear of non-pending id %0d", r_float_id);
    end
  end

  assign bus.err_o = r_err;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vanilla_sb_clear_gen.sv
//------------------------------------------------------------------------------
// Module  : tb_vanilla_sb_clear_gen
// Brief   : Directed self-checking bench for vanilla_sb_clear_gen.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vanilla_sb_clear_gen;
  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk_i = ~clk_i;

  vanilla_sb_clear_gen_if #(.data_width_p(32), .reg_addr_width_p(5)) bus ();

  vanilla_sb_clear_gen #(.data_width_p(32), .reg_addr_width_p(5), .fifo_els_p(2)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.remote_v_i       = 1'b0;
    bus.remote_float_i   = 1'b0;
    bus.remote_id_i      = '0;
    bus.remote_data_i    = '0;
    bus.idiv_v_i         = 1'b0;
    bus.idiv_id_i        = '0;
    bus.idiv_data_i      = '0;
    bus.fdiv_v_i         = 1'b0;
    bus.fdiv_id_i        = '0;
    bus.fdiv_data_i      = '0;
    bus.int_wb_stall_i   = 1'b0;
    bus.float_wb_stall_i = 1'b0;
`ifdef VANILLA_SB_CLEAR_CHECK_EN
    bus.int_sb_set_i      = 1'b0;
    bus.int_sb_set_id_i   = '0;
    bus.float_sb_set_i    = 1'b0;
    bus.float_sb_set_id_i = '0;
`endif
  endtask

  task automatic push(input logic fl, input logic [4:0] id, input logic [31:0] d);
    bus.remote_v_i     = 1'b1;
    bus.remote_float_i = fl;
    bus.remote_id_i    = id;
    bus.remote_data_i  = d;
  endtask

  task automatic do_reset();
    idle();
    reset_ni = 1'b0;
    @(negedge clk_i);
    reset_ni = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    reset_ni = 1'b0;
    #2;
    n_checks++; if (bus.int_sb_clear_o !== 1'b0) begin n_errors++; $display("FAIL rst_int_clear got %b exp 0", bus.int_sb_clear_o); end
    n_checks++; if (bus.float_sb_clear_o !== 1'b0) begin n_errors++; $display("FAIL rst_float_clear got %b exp 0", bus.float_sb_clear_o); end
    n_checks++; if (bus.int_sb_clear_id_o !== 5'd0 || bus.int_wb_data_o !== 32'd0) begin n_errors++; $display("FAIL rst_int_iddata got %0d/%h exp 0/0", bus.int_sb_clear_id_o, bus.int_wb_data_o); end
    n_checks++; if (bus.remote_ready_o !== 1'b1) begin n_errors++; $display("FAIL rst_ready got %b exp 1", bus.remote_ready_o); end
    n_checks++; if (bus.err_o !== 1'b0) begin n_errors++; $display("FAIL rst_err got %b exp 0", bus.err_o); end
    @(negedge clk_i);
    reset_ni = 1'b1;
    tick();
  endtask

  task automatic test_remote_latency();
    push(1'b0, 5'd7, 32'hDEAD_BEEF);
    #1;
    n_checks++; if (bus.remote_ready_o !== 1'b1) begin n_errors++; $display("FAIL t1_ready got %b exp 1", bus.remote_ready_o); end
    tick(); idle();
    n_checks++; if (bus.int_sb_clear_o !== 1'b0) begin n_errors++; $display("FAIL t1_early_pulse got %b exp 0", bus.int_sb_clear_o); end
    tick();
    n_checks++; if (bus.int_sb_clear_o !== 1'b1) begin n_errors++; $display("FAIL t1_pulse got %b exp 1", bus.int_sb_clear_o); end
    n_checks++; if (bus.int_sb_clear_id_o !== 5'd7) begin n_errors++; $display("FAIL t1_id got %0d exp 7", bus.int_sb_clear_id_o); end
    n_checks++; if (bus.int_wb_data_o !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL t1_data got %h exp deadbeef", bus.int_wb_data_o); end
    tick();
    n_checks++; if (bus.int_sb_clear_o !== 1'b0) begin n_errors++; $display("FAIL t1_pulse_end got %b exp 0", bus.int_sb_clear_o); end
    n_checks++; if (bus.int_sb_clear_id_o !== 5'd7) begin n_errors++; $display("FAIL t1_id_hold got %0d exp 7", bus.int_sb_clear_id_o); end
  endtask

  task automatic test_int_round_robin();
    do_reset();
    push(1'b0, 5'd9, 32'h99);
    tick(); idle();
    bus.idiv_v_i = 1'b1; bus.idiv_id_i = 5'd3; bus.idiv_data_i = 32'h33;
    #1;
    n_checks++; if (bus.idiv_yumi_o !== 1'b1) begin n_errors++; $display("FAIL t2_yumi0 got %b exp 1", bus.idiv_yumi_o); end
    tick();
    n_checks++; if (bus.int_sb_clear_o !== 1'b1 || bus.int_sb_clear_id_o !== 5'd3) begin n_errors++; $display("FAIL t2_pulse3 got %b/%0d exp 1/3", bus.int_sb_clear_o, bus.int_sb_clear_id_o); end
    bus.idiv_id_i = 5'd4; bus.idiv_data_i = 32'h44;
    #1;
    n_checks++; if (bus.idiv_yumi_o !== 1'b0) begin n_errors++; $display("FAIL t2_yumi1 got %b exp 0", bus.idiv_yumi_o); end
    tick();
    n_checks++; if (bus.int_sb_clear_o !== 1'b1 || bus.int_sb_clear_id_o !== 5'd9 || bus.int_wb_data_o !== 32'h99) begin n_errors++; $display("FAIL t2_pulse9 got %b/%0d/%h exp 1/9/99", bus.int_sb_clear_o, bus.int_sb_clear_id_o, bus.int_wb_data_o); end
    #1;
    n_checks++; if (bus.idiv_yumi_o !== 1'b1) begin n_errors++; $display("FAIL t2_yumi2 got %b exp 1", bus.idiv_yumi_o); end
    tick(); idle();
    n_checks++; if (bus.int_sb_clear_o !== 1'b1 || bus.int_sb_clear_id_o !== 5'd4 || bus.int_wb_data_o !== 32'h44) begin n_errors++; $display("FAIL t2_pulse4 got %b/%0d/%h exp 1/4/44", bus.int_sb_clear_o, bus.int_sb_clear_id_o, bus.int_wb_data_o); end
    tick();
    n_checks++; if (bus.int_sb_clear_o !== 1'b0) begin n_errors++; $display("FAIL t2_idle got %b exp 0", bus.int_sb_clear_o); end
  endtask

  task automatic test_fifo_full();
    bus.int_wb_stall_i = 1'b1;
    push(1'b0, 5'd10, 32'h10);
    tick();
    push(1'b0, 5'd11, 32'h11);
    #1;
    n_checks++; if (bus.remote_ready_o !== 1'b1) begin n_errors++; $display("FAIL t3_ready1 got %b exp 1", bus.remote_ready_o); end
    tick();
    push(1'b0, 5'd12, 32'h12);
    #1;
    n_checks++; if (bus.remote_ready_o !== 1'b0) begin n_errors++; $display("FAIL t3_full got %b exp 0", bus.remote_ready_o); end
    tick(); idle();
    n_checks++; if (bus.int_sb_clear_o !== 1'b0) begin n_errors++; $display("FAIL t3_stalled_pulse got %b exp 0", bus.int_sb_clear_o); end
    #1;
    n_checks++; if (bus.remote_ready_o !== 1'b0) begin n_errors++; $display("FAIL t3_ready_pop_cycle got %b exp 0", bus.remote_ready_o); end
    tick();
    n_checks++; if (bus.remote_ready_o !== 1'b1) begin n_errors++; $display("FAIL t3_ready_back got %b exp 1", bus.remote_ready_o); end
    n_checks++; if (bus.int_sb_clear_o !== 1'b1 || bus.int_sb_clear_id_o !== 5'd10) begin n_errors++; $display("FAIL t3_drain10 got %b/%0d exp 1/10", bus.int_sb_clear_o, bus.int_sb_clear_id_o); end
    tick();
    n_checks++; if (bus.int_sb_clear_o !== 1'b1 || bus.int_sb_clear_id_o !== 5'd11) begin n_errors++; $display("FAIL t3_drain11 got %b/%0d exp 1/11", bus.int_sb_clear_o, bus.int_sb_clear_id_o); end
    tick();
    n_checks++; if (bus.int_sb_clear_o !== 1'b0) begin n_errors++; $display("FAIL t3_no_12 got %b exp 0", bus.int_sb_clear_o); end
  endtask

  task automatic test_head_of_line();
    bus.float_wb_stall_i = 1'b1;
    push(1'b1, 5'd5, 32'h55);
    tick();
    push(1'b0, 5'd6, 32'h66);
    tick();
    bus.remote_v_i = 1'b0;
    n_checks++; if (bus.int_sb_clear_o !== 1'b0 || bus.float_sb_clear_o !== 1'b0) begin n_errors++; $display("FAIL t4_blocked_a got %b/%b exp 0/0", bus.int_sb_clear_o, bus.float_sb_clear_o); end
    tick();
    n_checks++; if (bus.int_sb_clear_o !== 1'b0) begin n_errors++; $display("FAIL t4_blocked_b got %b exp 0", bus.int_sb_clear_o); end
    bus.float_wb_stall_i = 1'b0;
    tick();
    n_checks++; if (bus.float_sb_clear_o !== 1'b1 || bus.float_sb_clear_id_o !== 5'd5 || bus.int_sb_clear_o !== 1'b0) begin n_errors++; $display("FAIL t4_float5 got %b/%0d int %b exp 1/5 int 0", bus.float_sb_clear_o, bus.float_sb_clear_id_o, bus.int_sb_clear_o); end
    tick();
    n_checks++; if (bus.int_sb_clear_o !== 1'b1 || bus.int_sb_clear_id_o !== 5'd6 || bus.float_sb_clear_o !== 1'b0) begin n_errors++; $display("FAIL t4_int6 got %b/%0d float %b exp 1/6 float 0", bus.int_sb_clear_o, bus.int_sb_clear_id_o, bus.float_sb_clear_o); end
  endtask

  task automatic test_dual_port();
    tick();
    push(1'b0, 5'd8, 32'h88);
    tick(); idle();
    bus.fdiv_v_i = 1'b1; bus.fdiv_id_i = 5'd2; bus.fdiv_data_i = 32'h22;
    #1;
    n_checks++; if (bus.fdiv_yumi_o !== 1'b1) begin n_errors++; $display("FAIL t5_fyumi got %b exp 1", bus.fdiv_yumi_o); end
    tick(); idle();
    n_checks++; if (bus.int_sb_clear_o !== 1'b1 || bus.int_sb_clear_id_o !== 5'd8 || bus.int_wb_data_o !== 32'h88) begin n_errors++; $display("FAIL t5_int8 got %b/%0d/%h exp 1/8/88", bus.int_sb_clear_o, bus.int_sb_clear_id_o, bus.int_wb_data_o); end
    n_checks++; if (bus.float_sb_clear_o !== 1'b1 || bus.float_sb_clear_id_o !== 5'd2 || bus.float_wb_data_o !== 32'h22) begin n_errors++; $display("FAIL t5_float2 got %b/%0d/%h exp 1/2/22", bus.float_sb_clear_o, bus.float_sb_clear_id_o, bus.float_wb_data_o); end
    tick();
    n_checks++; if (bus.int_sb_clear_o !== 1'b0 || bus.float_sb_clear_o !== 1'b0) begin n_errors++; $display("FAIL t5_end got %b/%b exp 0/0", bus.int_sb_clear_o, bus.float_sb_clear_o); end
  endtask

  task automatic test_reset_mid();
    bus.int_wb_stall_i = 1'b1;
    push(1'b0, 5'd13, 32'h13);
    tick();
    push(1'b0, 5'd14, 32'h14);
    bus.fdiv_v_i = 1'b1; bus.fdiv_id_i = 5'd1; bus.fdiv_data_i = 32'h1;
    tick();
    bus.remote_v_i = 1'b0; bus.fdiv_v_i = 1'b0;
    #1;
    n_checks++; if (bus.remote_ready_o !== 1'b0 || bus.float_sb_clear_o !== 1'b1) begin n_errors++; $display("FAIL tr_pre got ready %b float %b exp 0/1", bus.remote_ready_o, bus.float_sb_clear_o); end
    reset_ni = 1'b0;
    #1;
    n_checks++; if (bus.float_sb_clear_o !== 1'b0 || bus.float_sb_clear_id_o !== 5'd0) begin n_errors++; $display("FAIL tr_async_pulse got %b/%0d exp 0/0", bus.float_sb_clear_o, bus.float_sb_clear_id_o); end
    n_checks++; if (bus.remote_ready_o !== 1'b1) begin n_errors++; $display("FAIL tr_async_ready got %b exp 1", bus.remote_ready_o); end
    @(negedge clk_i);
    reset_ni = 1'b1;
    bus.int_wb_stall_i = 1'b0;
    tick(); tick();
    n_checks++; if (bus.int_sb_clear_o !== 1'b0) begin n_errors++; $display("FAIL tr_discarded got %b exp 0", bus.int_sb_clear_o); end
  endtask

  task automatic test_err_flag();
    do_reset();
    push(1'b0, 5'd12, 32'hC);
    tick(); idle();
    tick();
    n_checks++; if (bus.int_sb_clear_o !== 1'b1 || bus.int_sb_clear_id_o !== 5'd12) begin n_errors++; $display("FAIL t6_pulse got %b/%0d exp 1/12", bus.int_sb_clear_o, bus.int_sb_clear_id_o); end
    n_checks++; if (bus.err_o !== 1'b0) begin n_errors++; $display("FAIL t6_err_early got %b exp 0", bus.err_o); end
    tick();
`ifdef VANILLA_SB_CLEAR_CHECK_EN
    n_checks++; if (bus.err_o !== 1'b1) begin n_errors++; $display("FAIL t6_err_rise got %b exp 1", bus.err_o); end
    tick(); tick();
    n_checks++; if (bus.err_o !== 1'b1) begin n_errors++; $display("FAIL t6_err_sticky got %b exp 1", bus.err_o); end
`else
    n_checks++; if (bus.err_o !== 1'b0) begin n_errors++; $display("FAIL t6_err_tied got %b exp 0", bus.err_o); end
`endif
  endtask

  initial begin
    idle();
    test_reset();
    test_remote_latency();
    test_int_round_robin();
    test_fifo_full();
    test_head_of_line();
    test_dual_port();
    test_reset_mid();
    test_err_flag();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/vanilla_sb_clear_gen.md
Name: vanilla_sb_clear_gen

Overview:
- Response-side partner of the vanilla scoreboard tracker. It collects completions of long-latency ops: remote load/AMO responses from the network, idiv results and fdiv/fsqrt results.
- It arbitrates them onto the integer and float register-file writeback ports.
- It emits one-cycle `int_sb_clear`/`float_sb_clear` pulses with the register id, which release the scoreboard bits set at ID.
- Sits between the endpoint response path, the long-op units and the WB stage.

Parameters:
- `data_width_p`, 32, writeback data width.
- `reg_addr_width_p`, 5, register id width.
- `fifo_els_p`, 2, remote-response buffer depth (power of two, >=2).

Ports:
- `clk_i` in 1 clock
- `reset_ni` in 1 async active-low reset
- `remote_v_i` in 1 remote response valid
- `remote_float_i` in 1 response targets the float regfile
- `remote_id_i` in `reg_addr_width_p` destination register
- `remote_data_i` in `data_width_p` load/AMO data
- `remote_ready_o` out 1 buffer can accept
- `idiv_v_i` in 1 idiv result valid
- `idiv_id_i` in `reg_addr_width_p` rd
- `idiv_data_i` in `data_width_p` quotient/remainder
- `idiv_yumi_o` out 1 idiv result consumed
- `fdiv_v_i` in 1 fdiv/fsqrt result valid
- `fdiv_id_i` in `reg_addr_width_p` frd
- `fdiv_data_i` in `data_width_p` result
- `fdiv_yumi_o` out 1 fdiv result consumed
- `int_wb_stall_i` in 1 pipeline owns the int WB port this cycle
- `float_wb_stall_i` in 1 pipeline owns the float WB port this cycle
- `int_sb_clear_o` out 1 int clear/writeback pulse
- `int_sb_clear_id_o` out `reg_addr_width_p` cleared int register
- `int_wb_data_o` out `data_width_p` int writeback data
- `float_sb_clear_o` out 1 float clear/writeback pulse
- `float_sb_clear_id_o` out `reg_addr_width_p` cleared float register
- `float_wb_data_o` out `data_width_p` float writeback data
- `err_o` out 1 sticky protocol error (see Optional Feature)

Behaviour:
- Clocking and reset: single clock `clk_i`. Reset `reset_ni` is asynchronous, active-low. On reset:
  - FIFO emptied, all pulses 0, ids/data 0, `err_o`=0.
  - Both round-robin pointers set to "remote last", so the long-op unit wins the first tie.
- Remote buffer: circular FIFO of {float, id, data}, `fifo_els_p` entries, with wrapping read/write pointers and a count.
  - `remote_ready_o` = count < `fifo_els_p`, combinational from registered count only.
  - Enqueue on `remote_v_i & remote_ready_o`.
  - No same-cycle pass-through when full; simultaneous enqueue+dequeue when not full keeps count unchanged.
- Int port:
  - Candidates: `idiv_v_i`, and the FIFO head with float=0.
  - If `int_wb_stall_i`=1: no grant, `idiv_yumi_o`=0, FIFO not popped.
  - Otherwise a single requester wins. On a tie, the source not granted last wins; the pointer updates only on a grant.
  - `idiv_yumi_o` asserts combinationally in the grant cycle.
- Float port: same arbitration between `fdiv_v_i` and a float FIFO head, using `float_wb_stall_i` and `fdiv_yumi_o`.
- Head-of-line: only the FIFO head is eligible. A float head blocked by `float_wb_stall_i` blocks int-bound entries behind it.
- Outputs are registered. A grant in cycle N yields `*_sb_clear_o`=1 with id/data in cycle N+1, and pulse=0 in cycle N+2 unless granted again.
  - id/data hold their last value when the pulse is 0.
  - Back-to-back grants give back-to-back pulses.
- Latency: a remote response accepted in cycle N into an empty FIFO is granted in N+1 (if not stalled) and pulses in N+2. idiv/fdiv results are granted the same cycle they are valid and unstalled, and pulse next cycle.
- Throughput: at most one int and one float clear per cycle; both ports may pulse in the same cycle.
- Reset asserted mid-operation discards buffered entries and any pending pulse immediately (async).

Optional Feature:
- Macro `VANILLA_SB_CLEAR_CHECK_EN`. When defined, add inputs `int_sb_set_i`, `int_sb_set_id_i`, `float_sb_set_i`, `float_sb_set_id_i`, and keep shadow pending bit-vectors (`2**reg_addr_width_p` each).
  - A set marks the bit; a pulse clears it. Set and clear of the same id in one cycle: set wins.
  - A pulse on a non-pending id sets sticky `err_o` and issues `$error` with the id.
  - A set on an already-pending id also sets `err_o`.
- Undefined: no extra ports, no vectors, and `err_o` is tied 0.

Test Plan:
1. Reset, then remote response {float=0, id=7, data=0xDEAD_BEEF} into empty FIFO, no stall -> `int_sb_clear_o`=1, id=7, data=0xDEADBEEF exactly 2 cycles after acceptance, for one cycle.
2. `idiv_v_i` (id=3) and int FIFO head (id=9) both valid for 3 cycles after reset -> pulses id=3, then 9, with `idiv_yumi_o` in the first grant cycle only; the repeated idiv result (id=4) is granted on the third cycle.
3. Fill FIFO with 2 responses while `int_wb_stall_i`=1 -> `remote_ready_o`=0 on the third attempt, no pulses. Release stall -> ids drain in order; ready returns 1 the cycle after the first pop.
4. FIFO head float id=5 with `float_wb_stall_i`=1 and next entry int id=6 -> no int pulse while stalled. Unstall -> float pulse id=5, then int pulse id=6 one cycle later.
5. `fdiv_v_i` id=2 and remote int id=8 in the same cycle -> `float_sb_clear_o` and `int_sb_clear_o` pulse together (one cycle apart from their respective acceptance per latency rules).
6. With `VANILLA_SB_CLEAR_CHECK_EN`: remote response id=12 with no prior set -> `err_o` rises the cycle after the pulse and stays 1 until reset.
